// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline types for the load/store access unit: packets, FSM states,
// funct3 encodings and store lane placement.
package rv32i_types;

  localparam int ROB_IDX_W   = 5;
  localparam int PREG_W      = 6;
  localparam int AREG_W      = 5;
  localparam int STORE_TAG_W = 4;
  localparam int BMASK_W     = 4;
  localparam int BR_BIT_W    = 2;

  // Loads and stores share the width encodings; the U forms only exist for loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TAG,
    REQ,
    WAIT_RESP,
    DONE
  } mau_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             dmem_mask;
    logic [2:0]             mem_funct3;
    logic [ROB_IDX_W-1:0]   rob_idx;
    logic [PREG_W-1:0]      rd_paddr;
    logic [AREG_W-1:0]      rd_aaddr;
    logic                   i_use_store;
    logic [STORE_TAG_W-1:0] store_tag;
    logic                   store_tag_done;
    logic [BMASK_W-1:0]     bmask;
    rvfi_pkt_t              rvfi_pkt;
  } mem_pkt_t;

  typedef struct packed {
    logic                   st_tag_broadcast;
    logic [STORE_TAG_W-1:0] store_tag;
  } st_tag_pkt_t;

  typedef struct packed {
    logic                cdb_broadcast;
    logic                br_mispred;
    logic [BR_BIT_W-1:0] br_bit;
  } cdb_pkt_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    rd_paddr;
    logic [AREG_W-1:0]    rd_aaddr;
    logic [31:0]          rd_data;
    logic                 regf_we;
    rvfi_pkt_t            rvfi_pkt;
  } mem_result_pkt_t;

  // Shift the store payload into the byte lanes addressed by addr.
  function automatic logic [31:0] store_lane_data(input logic [2:0]  funct3,
                                                  input logic [1:0]  addr,
                                                  input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3)
      F3_B:    d = {24'b0, wdata[7:0]} << {addr, 3'b000};
      F3_H:    d = {16'b0, wdata[15:0]} << {addr[1], 4'b0000};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_data_align.sv
// Combinational load formatter: selects the addressed byte/half of a memory
// word and sign- or zero-extends it according to funct3.
module load_data_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rd_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    rd_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rd_data_o = {24'b0, byte_sel};
      F3_H:    rd_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rd_data_o = {16'b0, half_sel};
      default: rd_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: waits for store commit tags, issues one
// data-memory request, formats the response. Optional MEM_ACCESS_UNIT_PERF_CNT_EN adds perf counters.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  mem_pkt_t              in_pkt,
  output logic                  in_ready,
  input  st_tag_pkt_t           st_tag_pkt,
  input  cdb_pkt_t              cdb_pkt2,
  output logic [31:0]           dmem_addr,
  output logic [3:0]            dmem_rmask,
  output logic [3:0]            dmem_wmask,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_resp,
  output mem_result_pkt_t       out_pkt
`ifdef MEM_ACCESS_UNIT_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_loads,
  output logic [PERF_CNT_W-1:0] perf_stores,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

  mau_state_t         state_q, state_d;
  mem_pkt_t           pkt_q, pkt_d;
  logic               squash_q, squash_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [BMASK_W-1:0] br_onehot;
  logic               br_clear, br_kill;
  logic               held_hit, in_hit, held_spec;
  logic               tag_match_in, tag_match_q;
  logic               is_store;
  logic [31:0]        wdata_lane;
  logic [31:0]        load_data;

  assign br_onehot    = {{(BMASK_W-1){1'b0}}, 1'b1} << cdb_pkt2.br_bit;
  assign br_clear     = cdb_pkt2.cdb_broadcast && !cdb_pkt2.br_mispred;
  assign br_kill      = cdb_pkt2.cdb_broadcast && cdb_pkt2.br_mispred;
  assign held_hit     = br_kill && pkt_q.bmask[cdb_pkt2.br_bit];
  assign in_hit       = br_kill && in_pkt.bmask[cdb_pkt2.br_bit];
  assign tag_match_in = st_tag_pkt.st_tag_broadcast && (st_tag_pkt.store_tag == in_pkt.store_tag);
  assign tag_match_q  = st_tag_pkt.st_tag_broadcast && (st_tag_pkt.store_tag == pkt_q.store_tag);
  assign is_store     = pkt_q.i_use_store;
  // A store whose commit tag has arrived can no longer be squashed.
  assign held_spec    = !pkt_q.i_use_store || !pkt_q.store_tag_done;

  assign wdata_lane = store_lane_data(pkt_q.mem_funct3, pkt_q.mem_addr[1:0], pkt_q.mem_wdata);

  load_data_align u_align (
    .funct3_i  (pkt_q.mem_funct3),
    .addr_i    (pkt_q.mem_addr[1:0]),
    .rdata_i   (rdata_q),
    .rd_data_o (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pkt_q    <= '0;
      squash_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      squash_q <= squash_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    squash_d = squash_q;
    rdata_d  = rdata_q;
    if (br_clear) begin
      pkt_d.bmask = pkt_q.bmask & ~br_onehot;
    end

    case (state_q)
      IDLE: begin
        if (in_pkt.valid && !in_hit) begin
          pkt_d                = in_pkt;
          pkt_d.store_tag_done = in_pkt.store_tag_done || tag_match_in;
          if (br_clear) begin
            pkt_d.bmask = in_pkt.bmask & ~br_onehot;
          end
          squash_d = 1'b0;
          state_d  = (in_pkt.i_use_store && !pkt_d.store_tag_done) ? WAIT_TAG : REQ;
        end
      end
      WAIT_TAG: begin
        if (held_hit) begin
          pkt_d   = '0;
          state_d = IDLE;
        end else if (tag_match_q) begin
          pkt_d.store_tag_done = 1'b1;
          state_d              = REQ;
        end
      end
      REQ: begin
        // A response in this cycle belongs to nobody; the request is only now going out.
        if (held_hit && held_spec) begin
          squash_d = 1'b1;
        end
        state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (held_hit && held_spec) begin
          squash_d = 1'b1;
        end
        if (dmem_resp) begin
          rdata_d = dmem_rdata;
          if (squash_d) begin
            pkt_d    = '0;
            squash_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        pkt_d.valid = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    dmem_addr  = {pkt_q.mem_addr[31:2], 2'b00};
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    if (state_q == REQ) begin
      if (is_store) begin
        dmem_wmask = pkt_q.dmem_mask;
        dmem_wdata = wdata_lane;
      end else begin
        dmem_rmask = pkt_q.dmem_mask;
      end
    end
  end

  always_comb begin
    out_pkt = '0;
    if (state_q == DONE) begin
      out_pkt.valid              = pkt_q.valid && !squash_q && !(held_hit && held_spec);
      out_pkt.rob_idx            = pkt_q.rob_idx;
      out_pkt.rd_paddr           = pkt_q.rd_paddr;
      out_pkt.rd_aaddr           = pkt_q.rd_aaddr;
      out_pkt.rd_data            = is_store ? 32'h0 : load_data;
      out_pkt.regf_we            = !is_store && (pkt_q.rd_aaddr != '0);
      out_pkt.rvfi_pkt           = pkt_q.rvfi_pkt;
      out_pkt.rvfi_pkt.mem_addr  = pkt_q.mem_addr;
      out_pkt.rvfi_pkt.mem_rmask = is_store ? 4'b0000 : pkt_q.dmem_mask;
      out_pkt.rvfi_pkt.mem_wmask = is_store ? pkt_q.dmem_mask : 4'b0000;
      out_pkt.rvfi_pkt.mem_rdata = rdata_q;
      out_pkt.rvfi_pkt.mem_wdata = is_store ? wdata_lane : 32'h0;
    end
  end

`ifdef MEM_ACCESS_UNIT_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_loads_q, perf_stores_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (state_q == DONE && !is_store && out_pkt.valid) begin
        perf_loads_q <= perf_loads_q + PERF_CNT_W'(1);
      end
      if (state_q == DONE && is_store) begin
        perf_stores_q <= perf_stores_q + PERF_CNT_W'(1);
      end
      if (state_q == WAIT_TAG || state_q == WAIT_RESP) begin
        perf_stall_q <= perf_stall_q + PERF_CNT_W'(1);
      end
    end
  end

  assign perf_loads        = perf_loads_q;
  assign perf_stores       = perf_stores_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  localparam int perf_cnt_w_unused = PERF_CNT_W;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: load formatting table plus hand-written
// store-tag, mispredict and reset sequences.
module tb_mem_access_unit;
  import rv32i_types::*;

  logic            clk;
  logic            rst;
  mem_pkt_t        in_pkt;
  logic            in_ready;
  st_tag_pkt_t     st_tag_pkt;
  cdb_pkt_t        cdb_pkt2;
  logic [31:0]     dmem_addr;
  logic [3:0]      dmem_rmask;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic [31:0]     dmem_rdata;
  logic            dmem_resp;
  mem_result_pkt_t out_pkt;
`ifdef MEM_ACCESS_UNIT_PERF_CNT_EN
  logic [31:0]     perf_loads, perf_stores, perf_stall_cycles;
`endif

  mem_access_unit #(.PERF_CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pkt     (in_pkt),
    .in_ready   (in_ready),
    .st_tag_pkt (st_tag_pkt),
    .cdb_pkt2   (cdb_pkt2),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .out_pkt    (out_pkt)
`ifdef MEM_ACCESS_UNIT_PERF_CNT_EN
    ,
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_pkt_t mk_pkt(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] mask,
                                      input logic [4:0] rd, input logic [3:0] tag,
                                      input logic tag_done, input logic [3:0] bmask);
    mem_pkt_t p;
    p                = '0;
    p.valid          = 1'b1;
    p.mem_addr       = addr;
    p.mem_wdata      = wdata;
    p.dmem_mask      = mask;
    p.mem_funct3     = f3;
    p.rob_idx        = 5'd9;
    p.rd_paddr       = 6'd17;
    p.rd_aaddr       = rd;
    p.i_use_store    = st;
    p.store_tag      = tag;
    p.store_tag_done = tag_done;
    p.bmask          = bmask;
    p.rvfi_pkt.pc    = 32'h0000_0100;
    return p;
  endfunction

  function automatic cdb_pkt_t mk_cdb(input logic mis, input logic [1:0] bit_i);
    cdb_pkt_t c;
    c.cdb_broadcast = 1'b1;
    c.br_mispred    = mis;
    c.br_bit        = bit_i;
    return c;
  endfunction

  task automatic run_load(input vec_t v, input int id);
    in_pkt = mk_pkt(1'b0, v.f3, v.addr, 32'h0, v.mask, v.rd, 4'd0, 1'b0, 4'b0000);
    #1;
    chk($sformatf("v%0d_ready", id), {31'b0, in_ready}, 32'd1);
    tick();
    in_pkt = '0;
    #1;
    chk($sformatf("v%0d_rmask", id), {28'b0, dmem_rmask}, {28'b0, v.mask});
    chk($sformatf("v%0d_addr", id), dmem_addr, {v.addr[31:2], 2'b00});
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_early_valid", id), {31'b0, out_pkt.valid}, 32'd0);
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    chk($sformatf("v%0d_valid", id), {31'b0, out_pkt.valid}, 32'd1);
    chk($sformatf("v%0d_rd_data", id), out_pkt.rd_data, v.exp_data);
    chk($sformatf("v%0d_regf_we", id), {31'b0, out_pkt.regf_we}, {31'b0, v.exp_we});
    chk($sformatf("v%0d_rvfi_rdata", id), out_pkt.rvfi_pkt.mem_rdata, v.rdata);
    tick();
    #1;
    chk($sformatf("v%0d_valid_after", id), {31'b0, out_pkt.valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{F3_W,  32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 5'd3, 32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{F3_B,  32'h0000_1003, 4'b1000, 32'h80FF_FF7F, 5'd3, 32'hFFFF_FF80, 1'b1};
    vecs[2] = '{F3_BU, 32'h0000_1003, 4'b1000, 32'h80FF_FF7F, 5'd3, 32'h0000_0080, 1'b1};
    vecs[3] = '{F3_H,  32'h0000_1002, 4'b1100, 32'h80FF_FF7F, 5'd3, 32'hFFFF_80FF, 1'b1};
    vecs[4] = '{F3_HU, 32'h0000_1002, 4'b1100, 32'h80FF_FF7F, 5'd3, 32'h0000_80FF, 1'b1};
    vecs[5] = '{F3_B,  32'h0000_1000, 4'b0001, 32'h80FF_FF7F, 5'd4, 32'h0000_007F, 1'b1};
    vecs[6] = '{F3_H,  32'h0000_1000, 4'b0011, 32'h80FF_FF7F, 5'd4, 32'hFFFF_FF7F, 1'b1};
    vecs[7] = '{F3_B,  32'h0000_1001, 4'b0010, 32'h80FF_FF7F, 5'd4, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{F3_W,  32'h0000_1008, 4'b1111, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[9] = '{F3_BU, 32'h0000_1002, 4'b0100, 32'h1234_5678, 5'd7, 32'h0000_0034, 1'b1};

    rst        = 1'b1;
    in_pkt     = '0;
    st_tag_pkt = '0;
    cdb_pkt2   = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_pkt.valid}, 32'd0);
    chk("rst_rmask", {28'b0, dmem_rmask}, 32'd0);
    chk("rst_wmask", {28'b0, dmem_wmask}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_load(vecs[i], i);
    end

    // sw waits for tag 5; tag 3 must not release it
    in_pkt = mk_pkt(1'b1, F3_W, 32'h0000_2000, 32'hCAFE_F00D, 4'b1111, 5'd0, 4'd5, 1'b0, 4'b0000);
    tick();
    in_pkt     = '0;
    st_tag_pkt = '{1'b1, 4'd3};
    #1;
    chk("st_wait_wmask0", {28'b0, dmem_wmask}, 32'd0);
    tick();
    st_tag_pkt = '{1'b1, 4'd5};
    #1;
    chk("st_wait_wmask1", {28'b0, dmem_wmask}, 32'd0);
    chk("st_wait_ready", {31'b0, in_ready}, 32'd0);
    tick();
    st_tag_pkt = '0;
    #1;
    chk("st_wmask", {28'b0, dmem_wmask}, 32'hF);
    chk("st_rmask", {28'b0, dmem_rmask}, 32'd0);
    chk("st_wdata", dmem_wdata, 32'hCAFE_F00D);
    tick();
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("st_valid", {31'b0, out_pkt.valid}, 32'd1);
    chk("st_regf_we", {31'b0, out_pkt.regf_we}, 32'd0);
    chk("st_rd_data", out_pkt.rd_data, 32'd0);
    tick();

    // sb with matching tag in the accept cycle goes straight to REQ, byte placed in lane 1
    in_pkt     = mk_pkt(1'b1, F3_B, 32'h0000_2001, 32'h0000_00AB, 4'b0010, 5'd0, 4'd7, 1'b0, 4'b0000);
    st_tag_pkt = '{1'b1, 4'd7};
    tick();
    in_pkt     = '0;
    st_tag_pkt = '0;
    #1;
    chk("sb_wmask", {28'b0, dmem_wmask}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h0000_AB00);
    tick();
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    tick();

    // Mispredict while the load waits for memory: response consumed, no result
    in_pkt = mk_pkt(1'b0, F3_W, 32'h0000_3000, 32'h0, 4'b1111, 5'd2, 4'd0, 1'b0, 4'b0010);
    tick();
    in_pkt = '0;
    tick();
    cdb_pkt2 = mk_cdb(1'b1, 2'd1);
    tick();
    cdb_pkt2 = '0;
    #1;
    chk("mp_still_waiting", {31'b0, in_ready}, 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1111_2222;
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("mp_valid", {31'b0, out_pkt.valid}, 32'd0);
    chk("mp_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("mp_valid2", {31'b0, out_pkt.valid}, 32'd0);

    // Correct prediction clears the bit, so a later mispredict on it is harmless
    in_pkt = mk_pkt(1'b0, F3_W, 32'h0000_3004, 32'h0, 4'b1111, 5'd2, 4'd0, 1'b0, 4'b0010);
    tick();
    in_pkt   = '0;
    cdb_pkt2 = mk_cdb(1'b0, 2'd1);
    tick();
    cdb_pkt2   = mk_cdb(1'b1, 2'd1);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h0000_0055;
    tick();
    cdb_pkt2  = '0;
    dmem_resp = 1'b0;
    #1;
    chk("clr_valid", {31'b0, out_pkt.valid}, 32'd1);
    chk("clr_rd_data", out_pkt.rd_data, 32'h0000_0055);
    tick();

    // Mispredict in DONE suppresses the broadcast
    in_pkt = mk_pkt(1'b0, F3_W, 32'h0000_3008, 32'h0, 4'b1111, 5'd2, 4'd0, 1'b0, 4'b0100);
    tick();
    in_pkt = '0;
    tick();
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    cdb_pkt2  = mk_cdb(1'b1, 2'd2);
    #1;
    chk("done_mp_valid", {31'b0, out_pkt.valid}, 32'd0);
    tick();
    cdb_pkt2 = '0;

    // Mispredict at accept drops the packet
    in_pkt   = mk_pkt(1'b0, F3_W, 32'h0000_300C, 32'h0, 4'b1111, 5'd2, 4'd0, 1'b0, 4'b0001);
    cdb_pkt2 = mk_cdb(1'b1, 2'd0);
    tick();
    in_pkt   = '0;
    cdb_pkt2 = '0;
    #1;
    chk("acc_mp_rmask", {28'b0, dmem_rmask}, 32'd0);
    chk("acc_mp_ready", {31'b0, in_ready}, 32'd1);

    // Mispredict in WAIT_TAG wins over a same-cycle tag match
    in_pkt = mk_pkt(1'b1, F3_W, 32'h0000_2004, 32'h1234_5678, 4'b1111, 5'd0, 4'd2, 1'b0, 4'b1000);
    tick();
    in_pkt     = '0;
    cdb_pkt2   = mk_cdb(1'b1, 2'd3);
    st_tag_pkt = '{1'b1, 4'd2};
    tick();
    cdb_pkt2   = '0;
    st_tag_pkt = '0;
    #1;
    chk("wt_mp_wmask", {28'b0, dmem_wmask}, 32'd0);
    chk("wt_mp_ready", {31'b0, in_ready}, 32'd1);

    // Response during REQ is ignored; the real one arrives later
    in_pkt = mk_pkt(1'b0, F3_W, 32'h0000_4000, 32'h0, 4'b1111, 5'd6, 4'd0, 1'b0, 4'b0000);
    tick();
    in_pkt     = '0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("early_resp_ready", {31'b0, in_ready}, 32'd0);
    chk("early_resp_valid", {31'b0, out_pkt.valid}, 32'd0);
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1122_3344;
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("late_resp_valid", {31'b0, out_pkt.valid}, 32'd1);
    chk("late_resp_data", out_pkt.rd_data, 32'h1122_3344);
    tick();

    // Reset in WAIT_RESP; the trailing response must be ignored
    in_pkt = mk_pkt(1'b0, F3_W, 32'h0000_5000, 32'h0, 4'b1111, 5'd6, 4'd0, 1'b0, 4'b0000);
    tick();
    in_pkt = '0;
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h7777_7777;
    #1;
    chk("rstw_ready", {31'b0, in_ready}, 32'd1);
    tick();
    dmem_resp = 1'b0;
    #1;
    chk("rstw_valid", {31'b0, out_pkt.valid}, 32'd0);
    chk("rstw_ready2", {31'b0, in_ready}, 32'd1);
    chk("rstw_rmask", {28'b0, dmem_rmask}, 32'd0);
`ifdef MEM_ACCESS_UNIT_PERF_CNT_EN
    chk("rstw_perf_loads", perf_loads, 32'd0);
    chk("rstw_perf_stores", perf_stores, 32'd0);
    chk("rstw_perf_stall", perf_stall_cycles, 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
